// File: rtl/hps_system_keys_ctrl.sv
// hps_system_keys_ctrl: push-button controller on the lightweight HPS-to-FPGA
// bridge. It synchronises and debounces each key, captures press events in a
// sticky register, and raises a maskable level interrupt. Reads have a latency
// of one cycle.
module hps_system_keys_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync_p0;      // first synchroniser stage
    logic [WIDTH-1:0] sync_p1;      // second stage: the synchronised level
    logic [1:0]       live_p;       // marks when sync_p1 carries post-reset samples
    logic [WIDTH-1:0] deb;          // debounced level
    logic [WIDTH-1:0] deb_p1;       // debounced level one cycle late
    logic [WIDTH-1:0] armed;        // key seen released since reset
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] ec_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    deb_state_t       state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;

    // A press is a debounced 1->0 edge, only honoured once the key has been
    // seen released after reset so a key held through reset never reports.
    assign press  = deb_p1 & ~deb & armed;
    assign ec_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    assign unused_wdata = ^writedata[31:WIDTH];

    // Two-flop synchroniser plus a tracker of when its output is trustworthy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            live_p  <= '0;
        end else begin
            sync_p0 <= in_port;
            sync_p1 <= sync_p0;
            live_p  <= {live_p[0], 1'b1};
        end
    end

    // Per-key debounce FSM: a new level is accepted only after it has held
    // for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
            deb <= '1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    ST_STABLE: begin
                        if (sync_p1[i] != deb[i]) begin
                            state[i] <= ST_COUNTING;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    ST_COUNTING: begin
                        if (sync_p1[i] == deb[i]) begin
                            state[i] <= ST_STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            deb[i]   <= sync_p1[i];
                            state[i] <= ST_STABLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= ST_STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Edge detection, arming, sticky capture, mask register and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_p1      <= '1;
            armed       <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            deb_p1      <= deb;
            armed       <= armed | ({WIDTH{live_p[1]}} & sync_p1);
            edgecapture <= (edgecapture & ~ec_clr) | press;
            irq         <= |(edgecapture & irqmask);
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Register map read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd1:    rd_mux[WIDTH-1:0] = sync_p1;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            default: rd_mux[WIDTH-1:0] = edgecapture;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_hps_system_keys_ctrl.sv
// Testbench for hps_system_keys_ctrl: directed scenarios plus a randomized
// phase, checked by a scoreboard fed from a behavioural model of the key
// controller.
module tb_hps_system_keys_ctrl;

    localparam int W  = 2;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int total = 0;
    int bad   = 0;

    hps_system_keys_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] value;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    bit      rd_flag = 0;

    // Behavioural model state
    logic [W-1:0] m_raw1, m_sync;
    bit           m_real1, m_real2;
    logic [W-1:0] m_win [DB];      // most recent synchronised samples, [0] newest
    logic [W-1:0] m_deb, m_deb_q, m_armed, m_mask, m_ec;
    logic         m_irq = 1'b0;

    // Reference model: evaluated once per rising edge from pre-edge values.
    always @(posedge clk) begin
        logic [W-1:0] n_deb;
        logic [W-1:0] m_press;
        logic [W-1:0] m_clr;
        logic         n_irq;
        bit           all_diff;
        rd_exp_t      e;
        if (reset) begin
            m_raw1  = '1;
            m_sync  = '1;
            m_real1 = 0;
            m_real2 = 0;
            for (int k = 0; k < DB; k++) m_win[k] = '1;
            m_deb   = '1;
            m_deb_q = '1;
            m_armed = '0;
            m_mask  = '0;
            m_ec    = '0;
            m_irq   = 1'b0;
            e.addr  = 2'd0;
            e.value = 32'h0;
            exp_q.push_back(e);
            rd_flag = 1;
        end else begin
            if (chipselect && read) begin
                e.addr = address;
                case (address)
                    2'd0:    e.value = {{(32-W){1'b0}}, m_deb};
                    2'd1:    e.value = {{(32-W){1'b0}}, m_sync};
                    2'd2:    e.value = {{(32-W){1'b0}}, m_mask};
                    default: e.value = {{(32-W){1'b0}}, m_ec};
                endcase
                exp_q.push_back(e);
                rd_flag = 1;
            end
            m_press = m_deb_q & ~m_deb & m_armed;
            m_clr   = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
            n_irq   = |(m_ec & m_mask);
            m_ec    = (m_ec & ~m_clr) | m_press;
            if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
            m_irq = n_irq;
            // a key changes level when its last DB samples all disagree with it
            for (int k = DB - 1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = m_sync;
            n_deb = m_deb;
            for (int i = 0; i < W; i++) begin
                all_diff = 1;
                for (int k = 0; k < DB; k++)
                    if (m_win[k][i] == m_deb[i]) all_diff = 0;
                if (all_diff) n_deb[i] = m_sync[i];
            end
            for (int i = 0; i < W; i++)
                if (m_real2 && m_sync[i]) m_armed[i] = 1'b1;
            m_deb_q = m_deb;
            m_deb   = n_deb;
            m_sync  = m_raw1;
            m_real2 = m_real1;
            m_raw1  = in_port;
            m_real1 = 1;
        end
    end

    // Monitor: pops expected read data when a read response is due, and
    // checks the interrupt line every cycle.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_flag) begin
            rd_flag = 0;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_underflow got=%h required=<none>", readdata);
            end else begin
                e = exp_q.pop_front();
                if (readdata !== e.value) begin
                    bad++;
                    $display("FAIL rd_addr%0d got=%h required=%h at %0t", e.addr, readdata, e.value, $time);
                end
            end
        end
        total++;
        if (irq !== m_irq) begin
            bad++;
            $display("FAIL irq got=%0b required=%0b at %0t", irq, m_irq, $time);
        end
    end

    // One bus cycle: 0 idle, 1 read, 2 write.
    task automatic bus(input int op, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = (op != 0);
        read       = (op == 1);
        write      = (op == 2);
        address    = a;
        writedata  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(0, 2'd0, 32'h0);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) bus(1, 2'(i % 4), 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        chipselect = 0; read = 0; write = 0;
        for (int i = 1; i < n; i++) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int hold [W];

    initial begin
        reset = 1'b1;
        chipselect = 0; read = 0; write = 0;
        address = 2'd0; writedata = 32'h0;
        in_port = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset values of the register map
        bus(1, 2'd0, 0); bus(1, 2'd1, 0); bus(1, 2'd2, 0); bus(1, 2'd3, 0);
        idle(2);

        // key 0 press and hold, mask 0
        bus(0, 2'd0, 0);
        in_port[0] = 1'b0;
        reads(12);

        // key 1 bounce: low 3, high 1, low 10
        bus(1, 2'd1, 0); in_port[1] = 1'b0;
        bus(1, 2'd0, 0); bus(1, 2'd0, 0);
        bus(1, 2'd3, 0); in_port[1] = 1'b1;
        bus(1, 2'd0, 0); in_port[1] = 1'b0;
        for (int i = 0; i < 10; i++) bus(1, 2'(i % 2 == 0 ? 0 : 3), 0);
        reads(4);

        // unmask key 0, then clear its capture
        bus(2, 2'd2, 32'h1);
        reads(3);
        bus(2, 2'd3, 32'h1);
        reads(4);

        // writes to read-only addresses are ignored
        bus(2, 2'd0, 32'h0);
        bus(2, 2'd1, 32'h0);
        reads(4);

        // release, press (capture), release again
        bus(0, 2'd0, 0); in_port[0] = 1'b1;
        idle(10);
        bus(0, 2'd0, 0); in_port[0] = 1'b0;
        reads(12);
        bus(0, 2'd0, 0); in_port[0] = 1'b1;
        idle(10);
        // clear lands on the same edge a fresh press sets the capture bit
        bus(0, 2'd0, 0); in_port[0] = 1'b0;
        idle(5);
        bus(2, 2'd3, 32'h1);
        reads(6);

        // key held low across reset never reports a press
        bus(2, 2'd3, 32'h3);
        do_reset(1);
        for (int i = 0; i < 20; i++) bus(1, 2'(i % 2 == 0 ? 0 : 3), 0);
        // release and press again: now captured
        bus(0, 2'd0, 0); in_port = '1;
        idle(10);
        bus(0, 2'd0, 0); in_port[0] = 1'b0;
        reads(12);

        // randomized phase
        for (int k = 0; k < W; k++) hold[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45) bus(1, 2'($urandom_range(0, 3)), 0);
            else if (r < 55) bus(2, 2'($urandom_range(0, 3)), $urandom);
            else bus(0, 2'd0, 0);
            for (int k = 0; k < W; k++) begin
                if (hold[k] == 0) begin
                    in_port[k] = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 12));
                end else begin
                    hold[k]--;
                end
            end
            if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        idle(3);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
